// File: rtl/red_pitaya_iq_nco_pkg.sv
// ---------------------------------------------------------------------------
// red_pitaya_iq_nco_pkg
//
// Shared definitions for the IQ numerically controlled oscillator.
//   - NCO_LATENCY : clock cycles from the accumulator register to sin_o/cos_o.
//   - QUAD_*      : encoding of the top two phase bits (which quarter-wave).
//   - quad_mirrored / quad_negative : how a quadrant maps onto the
//     quarter-wave table (address mirror, output sign).
//   - lut_entry   : elaboration-time generator for the quarter-wave table.
// ---------------------------------------------------------------------------
package red_pitaya_iq_nco_pkg;

  // Accumulator register -> stage 1 phase -> stage 2 table read -> stage 3 sign.
  localparam int NCO_LATENCY = 3;

  typedef logic [1:0] quad_t;

  // Quadrant encoding: top two bits of the phase word.
  localparam quad_t QUAD_0 = 2'd0;  //   0 ..  90 deg : rising,  positive
  localparam quad_t QUAD_1 = 2'd1;  //  90 .. 180 deg : falling, positive
  localparam quad_t QUAD_2 = 2'd2;  // 180 .. 270 deg : falling, negative
  localparam quad_t QUAD_3 = 2'd3;  // 270 .. 360 deg : rising,  negative

  localparam real NCO_PI = 3.14159265358979323846;

  // Quadrants 1 and 3 read the table back to front.
  function automatic logic quad_mirrored(input quad_t q);
    return (q == QUAD_1) || (q == QUAD_3);
  endfunction

  // The second half of the period is the negated first half.
  function automatic logic quad_negative(input quad_t q);
    return (q == QUAD_2) || (q == QUAD_3);
  endfunction

  // Table entries are sampled at the middle of each step (k + 0.5), which
  // keeps every entry strictly positive and makes the mirrored read of
  // quadrants 1/3 exactly symmetric with quadrants 0/2.  Only evaluated at
  // elaboration, so the real arithmetic never reaches hardware.
  function automatic int lut_entry(input int k, input int lutbits, input int sinbits);
    real amp;
    real ang;
    amp = real'((1 << (sinbits - 1)) - 1);
    ang = 2.0 * NCO_PI * (real'(k) + 0.5) / real'(1 << (lutbits + 2));
    return $rtoi(amp * $sin(ang) + 0.5);
  endfunction

endpackage

// File: rtl/red_pitaya_iq_nco_lut.sv
// ---------------------------------------------------------------------------
// red_pitaya_iq_nco_lut
//
// Quarter-wave sine ROM with two synchronous read ports (one for the sine
// path, one for the cosine path).  Entries are unsigned magnitudes of
// SINBITS-1 bits; the sign is applied downstream.
//
// Ports
//   clk_i   : clock
//   rstn_i  : synchronous active-low reset, clears both read registers
//   clr_i   : synchronous clear of both read registers (pipeline bubble)
//   addr_a  : read address, port A
//   addr_b  : read address, port B
//   data_a  : registered read data, port A
//   data_b  : registered read data, port B
// ---------------------------------------------------------------------------
module red_pitaya_iq_nco_lut
  import red_pitaya_iq_nco_pkg::*;
#(
  parameter int LUTBITS = 11,
  parameter int SINBITS = 14
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               clr_i,
  input  logic [LUTBITS-1:0] addr_a,
  input  logic [LUTBITS-1:0] addr_b,
  output logic [SINBITS-2:0] data_a,
  output logic [SINBITS-2:0] data_b
);

  localparam int DEPTH   = 1 << LUTBITS;
  localparam int VALBITS = SINBITS - 1;

  logic [VALBITS-1:0] rom [DEPTH];

  // Contents are constants computed at elaboration; synthesis folds them
  // into a ROM.
  for (genvar k = 0; k < DEPTH; k++) begin : g_rom
    localparam logic [VALBITS-1:0] ENTRY = VALBITS'(lut_entry(k, LUTBITS, SINBITS));
    assign rom[k] = ENTRY;
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i || clr_i) begin
      data_a <= '0;
      data_b <= '0;
    end else begin
      data_a <= rom[addr_a];
      data_b <= rom[addr_b];
    end
  end

endmodule

// File: rtl/red_pitaya_iq_nco_block.sv
// ---------------------------------------------------------------------------
// red_pitaya_iq_nco_block
//
// Phase-accumulator NCO producing quadrature sine/cosine samples from a
// quarter-wave table.  Pipeline:
//   acc     : phase accumulator (plus registered phase offset and carry)
//   stage 1 : p = acc + phase, pc = p + quarter turn (top LUTBITS+2 bits kept)
//   stage 2 : table read (mirrored address in quadrants 1/3)
//   stage 3 : sign applied (negative in quadrants 2/3)
//
// Ports
//   clk_i   : clock
//   rstn_i  : synchronous active-low reset (overrides sync_i)
//   freq_i  : phase increment per cycle, unsigned
//   phase_i : static phase offset, unsigned
//   sync_i  : clears the accumulator
//   sin_o   : signed sine sample
//   cos_o   : signed cosine sample
//   wrap_o  : one-cycle pulse on the sample of the first post-wrap acc value
// ---------------------------------------------------------------------------
module red_pitaya_iq_nco_block
  import red_pitaya_iq_nco_pkg::*;
#(
  parameter int PHASEBITS = 32,
  parameter int LUTBITS   = 11,
  parameter int SINBITS   = 14
) (
  input  logic                        clk_i,
  input  logic                        rstn_i,
  input  logic        [PHASEBITS-1:0] freq_i,
  input  logic        [PHASEBITS-1:0] phase_i,
  input  logic                        sync_i,
  output logic signed [SINBITS-1:0]   sin_o,
  output logic signed [SINBITS-1:0]   cos_o,
  output logic                        wrap_o
);

  localparam int TOPBITS = LUTBITS + 2;
  localparam int LOWBITS = PHASEBITS - TOPBITS;
  localparam int VALBITS = SINBITS - 1;

  // A quarter turn expressed in the truncated (top-bits) phase domain.
  localparam logic [TOPBITS-1:0] QUARTER_TOP = TOPBITS'(1) << LUTBITS;

  // -------------------------------------------------------------------------
  // Accumulator stage
  // -------------------------------------------------------------------------
  logic [PHASEBITS-1:0] acc;
  logic [PHASEBITS-1:0] phase_r;
  logic                 acc_vld;
  logic                 acc_carry;
  logic [PHASEBITS:0]   acc_sum;

  always_comb begin
    acc_sum = {1'b0, acc} + {1'b0, freq_i};
  end

  // phase_i is registered next to acc so that phase and frequency changes
  // land on the same sample; acc_vld marks that acc holds a real update
  // (the zero left by reset is not emitted as a sample).
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      acc       <= '0;
      phase_r   <= '0;
      acc_vld   <= 1'b0;
      acc_carry <= 1'b0;
    end else begin
      acc_vld <= 1'b1;
      phase_r <= phase_i;
      if (sync_i) begin
        acc       <= '0;
        acc_carry <= 1'b0;
      end else begin
        acc       <= acc_sum[PHASEBITS-1:0];
        acc_carry <= acc_sum[PHASEBITS];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stage 1: offset phase, truncated to quadrant + table index
  // -------------------------------------------------------------------------
  logic               low_carry;
  logic [TOPBITS-1:0] p_top_c;
  logic [TOPBITS-1:0] pc_top_c;

  // Only the top bits of acc + phase are needed.  The carry out of the
  // discarded low bits is acc_low + phase_low >= 2^LOWBITS, which is the
  // same as acc_low > ~phase_low, so the low half needs only a comparator.
  always_comb begin
    low_carry = acc[LOWBITS-1:0] > ~phase_r[LOWBITS-1:0];
    p_top_c   = acc[PHASEBITS-1 -: TOPBITS] + phase_r[PHASEBITS-1 -: TOPBITS]
              + TOPBITS'(low_carry);
    pc_top_c  = p_top_c + QUARTER_TOP;
  end

  logic [TOPBITS-1:0] p_top;
  logic [TOPBITS-1:0] pc_top;
  logic               s1_vld;
  logic               s1_wrap;

  always_ff @(posedge clk_i) begin
    if (!rstn_i || !acc_vld) begin
      p_top   <= '0;
      pc_top  <= '0;
      s1_vld  <= 1'b0;
      s1_wrap <= 1'b0;
    end else begin
      p_top   <= p_top_c;
      pc_top  <= pc_top_c;
      s1_vld  <= 1'b1;
      s1_wrap <= acc_carry;
    end
  end

  // -------------------------------------------------------------------------
  // Stage 2: table read
  // -------------------------------------------------------------------------
  quad_t              sin_q;
  quad_t              cos_q;
  logic [LUTBITS-1:0] sin_idx;
  logic [LUTBITS-1:0] cos_idx;
  logic [LUTBITS-1:0] sin_addr;
  logic [LUTBITS-1:0] cos_addr;

  // In the falling quadrants the table is read back to front; ~idx is
  // 2^LUTBITS-1-idx without an adder.
  always_comb begin
    sin_q    = p_top[TOPBITS-1 -: 2];
    cos_q    = pc_top[TOPBITS-1 -: 2];
    sin_idx  = p_top[LUTBITS-1:0];
    cos_idx  = pc_top[LUTBITS-1:0];
    sin_addr = quad_mirrored(sin_q) ? ~sin_idx : sin_idx;
    cos_addr = quad_mirrored(cos_q) ? ~cos_idx : cos_idx;
  end

  logic [VALBITS-1:0] sin_mag;
  logic [VALBITS-1:0] cos_mag;

  red_pitaya_iq_nco_lut #(
    .LUTBITS (LUTBITS),
    .SINBITS (SINBITS)
  ) u_lut (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .clr_i  (!s1_vld),
    .addr_a (sin_addr),
    .addr_b (cos_addr),
    .data_a (sin_mag),
    .data_b (cos_mag)
  );

  logic s2_sin_neg;
  logic s2_cos_neg;
  logic s2_vld;
  logic s2_wrap;

  // Sign decisions travel alongside the table read.
  always_ff @(posedge clk_i) begin
    if (!rstn_i || !s1_vld) begin
      s2_sin_neg <= 1'b0;
      s2_cos_neg <= 1'b0;
      s2_vld     <= 1'b0;
      s2_wrap    <= 1'b0;
    end else begin
      s2_sin_neg <= quad_negative(sin_q);
      s2_cos_neg <= quad_negative(cos_q);
      s2_vld     <= 1'b1;
      s2_wrap    <= s1_wrap;
    end
  end

  // -------------------------------------------------------------------------
  // Stage 3: apply sign
  // -------------------------------------------------------------------------
  logic signed [SINBITS-1:0] sin_pos;
  logic signed [SINBITS-1:0] cos_pos;

  // Magnitudes never exceed 2^(SINBITS-1)-1, so negation cannot reach the
  // most negative code.
  always_comb begin
    sin_pos = {1'b0, sin_mag};
    cos_pos = {1'b0, cos_mag};
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i || !s2_vld) begin
      sin_o  <= '0;
      cos_o  <= '0;
      wrap_o <= 1'b0;
    end else begin
      sin_o  <= s2_sin_neg ? -sin_pos : sin_pos;
      cos_o  <= s2_cos_neg ? -cos_pos : cos_pos;
      wrap_o <= s2_wrap;
    end
  end

endmodule

// File: tb/tb_red_pitaya_iq_nco_block.sv
// ---------------------------------------------------------------------------
// tb_red_pitaya_iq_nco_block
//
// Directed bench for the IQ NCO with PHASEBITS=32, LUTBITS=11, SINBITS=14.
// Expected samples come from the quarter-wave table end points
// (lut[0]=3, lut[1]=9, lut[2047]=8191) and the quadrant rules.
// ---------------------------------------------------------------------------
module tb_red_pitaya_iq_nco_block;
  import red_pitaya_iq_nco_pkg::*;

  localparam int PB = 32;
  localparam int LB = 11;
  localparam int SB = 14;

  logic                 clk = 1'b0;
  logic                 rstn;
  logic        [PB-1:0] freq;
  logic        [PB-1:0] phase;
  logic                 sync;
  logic signed [SB-1:0] sin_s;
  logic signed [SB-1:0] cos_s;
  logic                 wrap;

  int checks   = 0;
  int failures = 0;

  int seq_sin[4] = '{3, 8191, -3, -8191};
  int seq_cos[4] = '{8191, -3, -8191, 3};

  red_pitaya_iq_nco_block #(
    .PHASEBITS (PB),
    .LUTBITS   (LB),
    .SINBITS   (SB)
  ) dut (
    .clk_i   (clk),
    .rstn_i  (rstn),
    .freq_i  (freq),
    .phase_i (phase),
    .sync_i  (sync),
    .sin_o   (sin_s),
    .cos_o   (cos_s),
    .wrap_o  (wrap)
  );

  always #5 clk = ~clk;

  // Advance n rising edges and sample 1 ns later.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One-cycle accumulator clear; the acc=0 sample shows up NCO_LATENCY ticks later.
  task automatic pulse_sync();
    sync = 1'b1;
    tick(1);
    sync = 1'b0;
  endtask

  task automatic test_reset();
    rstn  = 1'b0;
    sync  = 1'b1;
    freq  = 32'h4000_0000;
    phase = 32'h4000_0000;
    tick(2);
    checks++;
    if (sin_s !== 14'sd0) begin failures++; $display("[TB] FAIL reset_sin actual=%0d required=0", sin_s); end
    checks++;
    if (cos_s !== 14'sd0) begin failures++; $display("[TB] FAIL reset_cos actual=%0d required=0", cos_s); end
    checks++;
    if (wrap !== 1'b0) begin failures++; $display("[TB] FAIL reset_wrap actual=%b required=0", wrap); end
    freq  = '0;
    phase = '0;
    sync  = 1'b0;
    rstn  = 1'b1;
    tick(NCO_LATENCY);
    checks++;
    if (sin_s !== 14'sd0) begin failures++; $display("[TB] FAIL release_wait_sin actual=%0d required=0", sin_s); end
    tick(1);
    checks++;
    if (sin_s !== 14'sd3) begin failures++; $display("[TB] FAIL release_first_sin actual=%0d required=3", sin_s); end
  endtask

  task automatic test_dc();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (sin_s !== 14'sd3) begin failures++; $display("[TB] FAIL dc_sin[%0d] actual=%0d required=3", i, sin_s); end
      checks++;
      if (cos_s !== 14'sd8191) begin failures++; $display("[TB] FAIL dc_cos[%0d] actual=%0d required=8191", i, cos_s); end
      checks++;
      if (wrap !== 1'b0) begin failures++; $display("[TB] FAIL dc_wrap[%0d] actual=%b required=0", i, wrap); end
      tick(1);
    end
  endtask

  task automatic test_quarter_rate();
    logic signed [SB-1:0] es;
    logic signed [SB-1:0] ec;
    logic                 ew;
    freq = 32'h4000_0000;
    pulse_sync();
    tick(NCO_LATENCY);
    for (int i = 0; i < 8; i++) begin
      es = SB'(seq_sin[i % 4]);
      ec = SB'(seq_cos[i % 4]);
      ew = (i % 4 == 0) && (i != 0);
      checks++;
      if (sin_s !== es) begin failures++; $display("[TB] FAIL quarter_sin[%0d] actual=%0d required=%0d", i, sin_s, es); end
      checks++;
      if (cos_s !== ec) begin failures++; $display("[TB] FAIL quarter_cos[%0d] actual=%0d required=%0d", i, cos_s, ec); end
      checks++;
      if (wrap !== ew) begin failures++; $display("[TB] FAIL quarter_wrap[%0d] actual=%b required=%b", i, wrap, ew); end
      tick(1);
    end
  endtask

  task automatic test_nyquist();
    logic signed [SB-1:0] es;
    logic signed [SB-1:0] ec;
    logic                 ew;
    freq = 32'h8000_0000;
    pulse_sync();
    tick(NCO_LATENCY);
    for (int i = 0; i < 6; i++) begin
      es = (i % 2 == 0) ? 14'sd3 : -14'sd3;
      ec = (i % 2 == 0) ? 14'sd8191 : -14'sd8191;
      ew = (i % 2 == 0) && (i != 0);
      checks++;
      if (sin_s !== es) begin failures++; $display("[TB] FAIL nyq_sin[%0d] actual=%0d required=%0d", i, sin_s, es); end
      checks++;
      if (cos_s !== ec) begin failures++; $display("[TB] FAIL nyq_cos[%0d] actual=%0d required=%0d", i, cos_s, ec); end
      checks++;
      if (wrap !== ew) begin failures++; $display("[TB] FAIL nyq_wrap[%0d] actual=%b required=%b", i, wrap, ew); end
      tick(1);
    end
  endtask

  // Sync lands while the old stream is mid-flight: the three samples still
  // in the pipe come out unchanged, then the sequence restarts at 3.
  task automatic test_sync_restart();
    int exp_after[7] = '{-8191, 3, 8191, 3, 8191, -3, -8191};
    logic signed [SB-1:0] es;
    freq = 32'h4000_0000;
    pulse_sync();
    tick(NCO_LATENCY + 2);
    checks++;
    if (sin_s !== -14'sd3) begin failures++; $display("[TB] FAIL restart_pre actual=%0d required=-3", sin_s); end
    sync = 1'b1;
    for (int k = 0; k < 7; k++) begin
      tick(1);
      sync = 1'b0;
      es = SB'(exp_after[k]);
      checks++;
      if (sin_s !== es) begin failures++; $display("[TB] FAIL restart_sin[%0d] actual=%0d required=%0d", k, sin_s, es); end
      if (k == 3) begin
        checks++;
        if (wrap !== 1'b0) begin failures++; $display("[TB] FAIL restart_wrap actual=%b required=0", wrap); end
      end
    end
  endtask

  task automatic test_phase_step();
    freq  = '0;
    phase = 32'h4000_0000;
    pulse_sync();
    tick(NCO_LATENCY);
    checks++;
    if (sin_s !== 14'sd8191) begin failures++; $display("[TB] FAIL phase90_sin actual=%0d required=8191", sin_s); end
    checks++;
    if (cos_s !== -14'sd3) begin failures++; $display("[TB] FAIL phase90_cos actual=%0d required=-3", cos_s); end
    phase = '0;
    for (int k = 0; k < 3; k++) begin
      tick(1);
      checks++;
      if (sin_s !== 14'sd8191) begin failures++; $display("[TB] FAIL phase_hold[%0d] actual=%0d required=8191", k, sin_s); end
    end
    tick(1);
    checks++;
    if (sin_s !== 14'sd3) begin failures++; $display("[TB] FAIL phase0_sin actual=%0d required=3", sin_s); end
    checks++;
    if (cos_s !== 14'sd8191) begin failures++; $display("[TB] FAIL phase0_cos actual=%0d required=8191", cos_s); end
  endtask

  task automatic test_reset_midrun();
    freq = 32'h4000_0000;
    pulse_sync();
    tick(5);
    rstn = 1'b0;
    tick(1);
    checks++;
    if (sin_s !== 14'sd0) begin failures++; $display("[TB] FAIL midrst_sin actual=%0d required=0", sin_s); end
    checks++;
    if (cos_s !== 14'sd0) begin failures++; $display("[TB] FAIL midrst_cos actual=%0d required=0", cos_s); end
    checks++;
    if (wrap !== 1'b0) begin failures++; $display("[TB] FAIL midrst_wrap actual=%b required=0", wrap); end
    rstn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick(1);
      checks++;
      if (sin_s !== 14'sd0 || cos_s !== 14'sd0) begin
        failures++;
        $display("[TB] FAIL midrst_flush[%0d] actual=%0d/%0d required=0/0", k, sin_s, cos_s);
      end
    end
    tick(1);
    checks++;
    if (sin_s !== 14'sd8191) begin failures++; $display("[TB] FAIL midrst_first_sin actual=%0d required=8191", sin_s); end
    checks++;
    if (cos_s !== -14'sd3) begin failures++; $display("[TB] FAIL midrst_first_cos actual=%0d required=-3", cos_s); end
  endtask

  // freq = 2^19 walks the 13 truncated phase bits through every value once.
  task automatic test_sweep();
    int max_s = -100000;
    int min_s = 100000;
    int max_c = -100000;
    int min_c = 100000;
    int wraps = 0;
    int s;
    int c;
    freq  = 32'h0008_0000;
    phase = '0;
    pulse_sync();
    tick(NCO_LATENCY);
    for (int i = 0; i <= 8192; i++) begin
      s = int'(sin_s);
      c = int'(cos_s);
      if (s > max_s) max_s = s;
      if (s < min_s) min_s = s;
      if (c > max_c) max_c = c;
      if (c < min_c) min_c = c;
      if (wrap === 1'b1) wraps++;
      if (i == 1) begin
        checks++;
        if (sin_s !== 14'sd9) begin failures++; $display("[TB] FAIL sweep_lut1 actual=%0d required=9", sin_s); end
      end
      if (i == 2048) begin
        checks++;
        if (sin_s !== 14'sd8191) begin failures++; $display("[TB] FAIL sweep_q1 actual=%0d required=8191", sin_s); end
      end
      if (i == 6144) begin
        checks++;
        if (sin_s !== -14'sd8191) begin failures++; $display("[TB] FAIL sweep_q3 actual=%0d required=-8191", sin_s); end
      end
      tick(1);
    end
    checks++;
    if (max_s != 8191) begin failures++; $display("[TB] FAIL sweep_max_sin actual=%0d required=8191", max_s); end
    checks++;
    if (min_s != -8191) begin failures++; $display("[TB] FAIL sweep_min_sin actual=%0d required=-8191", min_s); end
    checks++;
    if (max_c != 8191) begin failures++; $display("[TB] FAIL sweep_max_cos actual=%0d required=8191", max_c); end
    checks++;
    if (min_c != -8191) begin failures++; $display("[TB] FAIL sweep_min_cos actual=%0d required=-8191", min_c); end
    checks++;
    if (wraps != 1) begin failures++; $display("[TB] FAIL sweep_wraps actual=%0d required=1", wraps); end
  endtask

  initial begin
    rstn  = 1'b0;
    sync  = 1'b0;
    freq  = '0;
    phase = '0;
    test_reset();
    test_dc();
    test_quarter_rate();
    test_nyquist();
    test_sync_restart();
    test_phase_step();
    test_reset_midrun();
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL timeout actual=running required=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule

// File: doc/red_pitaya_iq_nco_block.md
RED_PITAYA_IQ_NCO_BLOCK -- requirements
Module: red_pitaya_iq_nco_block

Interface
REQ-001 SHALL have parameter PHASEBITS, default 32, phase accumulator width.
REQ-002 SHALL have parameter LUTBITS, default 11, quarter-wave table address width (table depth 2^LUTBITS).
REQ-003 SHALL have parameter SINBITS, default 14, signed width of sin_o/cos_o; matches the modulator's sin/cos inputs.
REQ-004 SHALL have port clk_i, input, 1 bit: single clock; one clock; reset is synchronous and active-low.
REQ-005 SHALL have port rstn_i, input, 1 bit: synchronous active-low reset.
REQ-006 SHALL have port freq_i, input, PHASEBITS, unsigned phase increment per cycle.
REQ-007 SHALL have port phase_i, input, PHASEBITS, unsigned static phase offset added after the accumulator.
REQ-008 SHALL have port sync_i, input, 1 bit: accumulator clear request.
REQ-009 SHALL have port sin_o, output, SINBITS signed: sine sample.
REQ-010 SHALL have port cos_o, output, SINBITS signed: cosine sample.
REQ-011 SHALL have port wrap_o, output, 1 bit: one-cycle pulse marking accumulator carry-out.

Function
REQ-012 Accumulator acc SHALL update every cycle: sync_i=1 -> acc<=0; else acc<=acc+freq_i modulo 2^PHASEBITS.
REQ-013 Carry SHALL be the carry-out of acc+freq_i; it is forced to 0 when sync_i=1.
REQ-014 Stage 1 SHALL register p = acc+phase_i modulo 2^PHASEBITS, and pc = p + 2^(PHASEBITS-2) for cosine.
REQ-015 Only the top LUTBITS+2 bits of p/pc SHALL be used: top 2 bits = quadrant q, next LUTBITS = index i; lower bits are truncated, not rounded.
REQ-016 Table SHALL hold lut[k] = round((2^(SINBITS-1)-1)*sin(2*pi*(k+0.5)/2^(LUTBITS+2))), k = 0..2^LUTBITS-1, all entries positive.
REQ-017 Stage 2 SHALL register the table read at address i for q in {0,2}, and at address 2^LUTBITS-1-i for q in {1,3}; the read is registered.
REQ-018 Stage 3 SHALL output +value for q in {0,1} and -value for q in {2,3}; |sin_o|,|cos_o| <= 2^(SINBITS-1)-1, so the value -2^(SINBITS-1) is never produced.
REQ-019 Latency from acc register to sin_o/cos_o SHALL be exactly 3 cycles, with 4 cycles from sync_i or freq_i sampled to the corresponding sample.
REQ-020 wrap_o SHALL be the carry delayed so it is aligned with the sample of the first post-wrap acc value.
REQ-021 freq_i/phase_i changes SHALL take effect on the next edge with no glitch or phase jump other than the programmed one; phase continuity across freq_i changes is required.
REQ-022 A sync_i held high SHALL keep acc at 0, so outputs settle to a constant after 4 cycles.
REQ-023 freq_i=0 SHALL yield constant outputs; freq_i=2^(PHASEBITS-1) SHALL yield the Nyquist alternation.

Reset
REQ-024 While rstn_i=0 at the clock edge, acc, stage-1 phase registers, table output registers, sin_o, cos_o and wrap_o SHALL all be 0.
REQ-025 Reset SHALL override sync_i, and a mid-operation reset SHALL discard all in-flight pipeline samples.
REQ-026 After release, first valid table-derived sample SHALL appear 3 cycles after the first acc update; before that, outputs remain 0.

Structure
REQ-027 Pipeline-latency constant (3) and quadrant encoding SHALL be localparams in a shared header used by the block and bench.
REQ-028 Table SHALL be one sub-module red_pitaya_iq_nco_lut (synchronous ROM, dual read port, parameters LUTBITS/SINBITS, contents generated at elaboration or from a mem file).
REQ-029 No multipliers SHALL be used; the block is adders, registers and ROM only.

Verification (PHASEBITS=32, LUTBITS=11, SINBITS=14; lut[0]=3, lut[2047]=8191)
REQ-030 Test 1: reset, freq_i=0, phase_i=0 -> sin_o=3, cos_o=8191 steady; wrap_o=0.
REQ-031 Test 2: freq_i=2^30 -> sin_o sequence 3,8191,-3,-8191 repeating; cos_o 8191,-3,-8191,3; wrap_o high once per 4 cycles, coincident with sin_o=3.
REQ-032 Test 3: freq_i=2^31 -> sin_o alternates 3,-3; wrap_o every 2nd cycle.
REQ-033 Test 4: freq_i=2^30 running, pulse sync_i for 1 cycle -> exactly 4 cycles later sin_o=3 and the sequence restarts from 3.
REQ-034 Test 5: phase_i=2^30, freq_i=0 -> sin_o=8191, cos_o=-3; change phase_i to 0 -> sin_o=3 after 4 cycles, no intermediate value.
REQ-035 Test 6: rstn_i low mid-run for 1 cycle -> all outputs 0 next cycle; first nonzero sample 4 cycles after release; a sweep over all acc top bits gives max |sin_o| = 8191, never -8192.
